// File: rtl/arb_pkg.sv
// Shared types for the N-way arbiter: arbitration mode and lock state.
package arb_pkg;

    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_t;
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: round-robin from ptr or fixed lowest-index
// priority, built on a double-width masked priority encoder.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    input  arb_mode_t       mode,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] idx,
    output logic            any_gnt
);

    logic [2*N-1:0] doubled;
    logic [2*N-1:0] masked;

    // The upper copy of req supplies the wrapped-around part of the search,
    // so the lowest surviving bit is always the next requester at or after ptr.
    always_comb begin
        doubled = {req, req};
        masked  = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (mode == ARB_FIXED)
                masked[i] = doubled[i] & (i < N);
            else
                masked[i] = doubled[i] & (i >= int'(ptr));
        end
    end

    always_comb begin
        idx     = '0;
        any_gnt = 1'b0;
        gnt     = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                any_gnt = 1'b1;
                idx     = IDXW'((i >= N) ? (i - N) : i);
            end
        end
        if (any_gnt)
            gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way valid/ready arbiter with round-robin or fixed priority, multi-flit
// packet locking and a single registered output stage.
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 33,
    localparam int IDXW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [N-1:0]       req_valid,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_last,
    output logic [N-1:0]       req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IDXW-1:0]    out_idx,
    output logic               out_last
);

    arb_state_t      state;
    logic [IDXW-1:0] lock_idx;
    logic [IDXW-1:0] ptr;

    logic [N-1:0]    pick_gnt;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

    logic            can_load;
    logic [IDXW-1:0] win_idx;
    logic            win_valid;
    logic            xfer;
    logic [WIDTH-1:0] win_data;
    logic            win_last;
    logic [IDXW-1:0] next_ptr;

    rr_pick #(.N(N)) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .mode    (arb_mode_t'(mode)),
        .gnt     (pick_gnt),
        .idx     (pick_idx),
        .any_gnt (pick_any)
    );

    // While locked the grant is pinned to the packet owner even if it stalls.
    always_comb begin
        can_load = !out_valid || out_ready;
        if (state == ARB_LOCKED) begin
            win_idx   = lock_idx;
            win_valid = req_valid[lock_idx];
        end else begin
            win_idx   = pick_idx;
            win_valid = pick_any;
        end
        req_ready = '0;
        if (rst_n && can_load && win_valid)
            req_ready[win_idx] = 1'b1;
        xfer = |req_ready;
    end

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (IDXW'(i) == win_idx) begin
                win_data = req_data[i*WIDTH +: WIDTH];
                win_last = req_last[i];
            end
        end
        next_ptr = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + 1'b1;
    end

    // A whole packet counts as one turn, so ptr only advances on its last flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            lock_idx <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            if (win_last) begin
                state <= ARB_IDLE;
                ptr   <= next_ptr;
            end else begin
                state    <= ARB_LOCKED;
                lock_idx <= win_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_idx   <= win_idx;
            out_last  <= win_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Clocked N-way arbiter with payload merge. Each requester supplies a WIDTH-bit payload over a valid/ready channel. The block selects one requester per cycle and forwards its payload, tagged with the winner index, into a single registered output channel. It supersedes the two-input random arbiter as the shared-resource front end of the mesh router and PE nodes. It adds N-way fairness, a selectable arbitration mode, and multi-flit packet locking.

## Interface
- N, 4: number of requesters; legal range 2–16.
- WIDTH, 33: payload width in bits.
- IDXW, $clog2(N): width of the winner index; derived, not overridden.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = round-robin, 1 = fixed priority (index 0 highest); sampled only at a grant decision.
- req_valid  in  N  per-requester valid.
- req_data  in  N*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  N  per-requester last-flit marker; 1 for single-flit transfers.
- req_ready  out  N  per-requester accept; one-hot or zero.
- out_valid  out  1  output register holds a flit.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  forwarded payload.
- out_idx  out  IDXW  index of the requester that supplied out_data.
- out_last  out  1  copy of req_last for the forwarded flit.

## Operation
- A transfer on requester i occurs when req_valid[i] & req_ready[i] at a clock edge. An output transfer occurs when out_valid & out_ready.
- Output register "can load" when !out_valid | out_ready.
- req_ready[i] = can_load & (i == grant) & req_valid[i]. It is combinational from req_valid, lock state, pointer and out_ready. It never depends on req_data.
- States:
  - IDLE (no lock): grant is chosen among asserted req_valid bits.
  - LOCKED(k): grant is held at k regardless of other requests.
  - IDLE → LOCKED(k) when requester k transfers with req_last = 0.
  - LOCKED(k) → IDLE when requester k transfers with req_last = 1.
- Round-robin mode: the search starts at pointer ptr and wraps from N-1 to 0. ptr updates to (winner+1) mod N only on a transfer with req_last = 1, so a packet counts as one turn.
- Fixed mode: the lowest asserted index wins. ptr is still updated as above, so switching mode mid-run is safe.
- In LOCKED(k), if req_valid[k] drops, no requester is granted and the lock persists. Other requesters wait.
- A mode change while LOCKED takes effect at the next IDLE decision.
- If no req_valid bit is asserted, no grant is made and ptr is unchanged.
- Once out_valid is asserted, out_data, out_idx and out_last stay stable until the output transfer.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0.
  - ptr = 0, state = IDLE.
  - req_ready = 0 while reset is asserted.
- Latency: a flit accepted at edge t appears with out_valid = 1 after edge t. This is 1 cycle.
- Throughput: one flit per cycle while out_ready is held at 1.
- Simultaneous output drain and new accept in the same cycle: the register is overwritten with the new flit and out_valid stays 1.
- Backpressure: out_valid = 1 & out_ready = 0 forces req_ready = 0 for all requesters.
- Reset asserted mid-packet clears the lock and ptr immediately. The partial packet is the upstream's responsibility.

## Structure
- Package arb_pkg holds:
  - typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_t;
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t.
- Sub-module rr_pick #(N) is purely combinational. Inputs are req[N], ptr, mode. Outputs are a one-hot gnt[N], the encoded idx and any_gnt.
- rr_pick uses a double-width masked priority encoder and is unit-tested separately.
- The top level holds the lock FSM, ptr, the output register and the payload mux.

## Test plan
- Reset check: rst_n = 0 with all req_valid = 1 → req_ready = 0, out_valid = 0. After release, ptr = 0, so requester 0 is granted first.
- Round-robin sweep: N = 4, all four valid, single-flit, out_ready = 1 → out_idx sequence is 0,1,2,3,0. Each requester's data is forwarded unchanged, e.g. 33'h1_0000_000i.
- Fixed priority: mode = 1, requesters 1 and 3 valid continuously → out_idx stays 1 and requester 3 is starved. Switching to mode = 0 → next grant is 3 (ptr = 2).
- Packet lock: requester 2 sends 3 flits (last on the third) while 0 and 1 are valid → out_idx = 2,2,2, then 0. A gap in req_valid[2] mid-packet produces no foreign grant.
- Backpressure: out_ready held at 0 for 5 cycles with a flit pending → out_data stable and req_ready all 0. On release, one flit drains per cycle.
- Reset mid-packet: assert rst_n low after flit 1 of a 3-flit packet from requester 3 → after release, state is IDLE and requester 0 wins when valid.
